deconv_serial_loader: RTL and testbench
=======================================

# deconv_serial_loader

Serial input deserializer for the deconvolution kernel estimator. It receives the one-bit, LSB-first word stream gated by `load_en` and assembles `DATA_WIDTH`-bit words. Each completed word is steered, per `sram_select` and `adc_bypass_en`, to the phase-vector SRAM write port, the TF-coefficient SRAM write port, or the ADC-bypass holding register. It is the receive-side counterpart of the output serializer and sits between the chip-level serial pins and the input SRAMs.

## Interface
- `DATA_WIDTH`, 16: word width, in bits.
- `ADDR_WIDTH`, 12: width of the SRAM write address and the word counter.
- `clk` in 1: single clock. Everything samples on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load_en` in 1: frames a load burst. While high, one serial bit is taken per cycle.
- `serial_in` in 1: serial data, LSB of each word first.
- `sram_select` in 2: burst target.
- `adc_bypass_en` in 1: when high at word completion, the word goes to the bypass register.
- `phase_wr_en` out 1: one-cycle write strobe to the phase-vector SRAM.
- `tf_coeff_wr_en` out 1: one-cycle write strobe to the TF-coefficient SRAM.
- `wr_addr` out `ADDR_WIDTH`: write address shared by both SRAMs.
- `wr_data` out `DATA_WIDTH`: write data shared by both SRAMs.
- `adc_bypass_data` out `DATA_WIDTH`: last word loaded with bypass enabled.
- `load_busy` out 1: high while in the SHIFT state.
- `load_overflow` out 1: sticky flag. Set when the word counter wraps.
- `select_error` out 1: sticky flag. Set when a word completes with an illegal target.

## Operation
- **FSM states:** IDLE and SHIFT.
- **IDLE → SHIFT:** on the first edge where `load_en`=1.
  - `serial_in` is captured at that same edge as bit 0.
  - `sram_select` is latched at that same edge and held for the whole burst.
- **SHIFT, `load_en`=1:** the shift register takes `serial_in` into bit position `bit_cnt`, and `bit_cnt` increments.
- **Word completion:** happens when `bit_cnt` = `DATA_WIDTH`-1 is captured.
  - If `adc_bypass_en`=1: `adc_bypass_data` ← word. No SRAM strobe. The word counter does not advance.
  - Else if the latched select is 2'b00: `phase_wr_en` pulses. If 2'b01: `tf_coeff_wr_en` pulses. In both cases `wr_addr` = word counter, `wr_data` = word, and the word counter increments.
  - Else (select 2'b10 or 2'b11, the output SRAMs): the word is discarded, `select_error` is set, and the counter is unchanged.
- **Counter wrap:** the word counter wraps modulo 2^`ADDR_WIDTH`. A write issued at address all-ones sets `load_overflow`.
- **SHIFT → IDLE:** on the first edge where `load_en`=0.
  - `bit_cnt` and the word counter clear.
  - A partial word is dropped with no strobe and no bypass update.
- **`adc_bypass_en` sampling:** sampled only at the completion edge, so it may drop one cycle after `load_en` falls.
- **Sticky flags:** cleared only by `rst_n`.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, counters 0. Reset is effective mid-word and mid-burst.
- **Strobe timing:** bit 0 is captured at edge E. Bit `DATA_WIDTH`-1 is captured at edge E+`DATA_WIDTH`-1. The write strobe is high for exactly the cycle following that edge, with `wr_addr`/`wr_data` valid alongside it.
- **Data hold:** `wr_addr`/`wr_data` hold their values until the next completion.
- **Back-to-back words:** the strobe is high one cycle in every `DATA_WIDTH` cycles. There are no gap cycles between words.
- **`load_busy`:** rises in the cycle after edge E and falls in the cycle after `load_en` is sampled low.
- **Simultaneous events:** if `load_en` falls on the cycle following a completion, the strobe still issues and the counter then clears.

## Configuration
- Macro: `DECONV_LOADER_INPUT_SYNC_EN`.
  - **Defined:** `load_en`, `serial_in`, `sram_select` and `adc_bypass_en` each pass through a two-flop synchronizer (reset value 0) before the FSM. All latencies above grow by 2 cycles.
  - **Undefined:** the inputs are used directly. Only synchronous stimulus is then permitted.

## Structure
- **Package `deconv_loader_pkg`:** select encodings `SEL_PHASE`=2'b00, `SEL_TF_COEFF`=2'b01, `SEL_OUT_MAG`=2'b10, `SEL_OUT_PHASE`=2'b11, plus the FSM state typedef.
- **Sub-module `serial_word_shifter`:** the bit counter, the LSB-first shift register and a `word_done` pulse, parameterized by `DATA_WIDTH`.

## Test plan
- **Basic write:** select 00, stream 0xA5C3 then 0x1234 LSB-first. Expect `phase_wr_en` pulses 16 cycles apart: (addr 0, 0xA5C3) then (addr 1, 0x1234). Expect `tf_coeff_wr_en` to stay 0.
- **Fresh burst:** select 01, 3 words, `load_en` low 2 cycles, then 2 more words. Expect addresses 0,1,2 then 0,1 on `tf_coeff_wr_en`.
- **ADC bypass:** `adc_bypass_en`=1, load 0x004F, drop `load_en` and one cycle later drop `adc_bypass_en`. Expect `adc_bypass_data`=0x004F and no SRAM strobe.
- **Partial word:** `load_en` drops after 7 bits. Expect no strobe, and the next burst's first word written at addr 0.
- **Wrap and illegal select:** with `ADDR_WIDTH`=3, 9 words on select 00. Expect the 9th word at addr 0 and `load_overflow`=1. Then select 10 with one word: expect no strobe and `select_error`=1.
- **Reset mid-operation:** assert `rst_n` low mid-word. Expect all outputs 0 immediately (asynchronous), and the following burst to start at bit 0, addr 0.

Source files
------------

// File: rtl/deconv_serial_loader_pkg.sv
// rtl/deconv_serial_loader_pkg.sv - select encodings and FSM state type for the serial loader
package deconv_loader_pkg;

    localparam logic [1:0] SEL_PHASE     = 2'b00;
    localparam logic [1:0] SEL_TF_COEFF  = 2'b01;
    localparam logic [1:0] SEL_OUT_MAG   = 2'b10;
    localparam logic [1:0] SEL_OUT_PHASE = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

endpackage

// File: rtl/deconv_serial_loader_if.sv
// rtl/deconv_serial_loader_if.sv - serial load pins and SRAM write port bundle
interface deconv_serial_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);

    logic                  load_en;
    logic                  serial_in;
    logic [1:0]            sram_select;
    logic                  adc_bypass_en;
    logic                  phase_wr_en;
    logic                  tf_coeff_wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] adc_bypass_data;
    logic                  load_busy;
    logic                  load_overflow;
    logic                  select_error;

    modport master (
        output load_en, serial_in, sram_select, adc_bypass_en,
        input  phase_wr_en, tf_coeff_wr_en, wr_addr, wr_data,
        input  adc_bypass_data, load_busy, load_overflow, select_error
    );

    modport slave (
        input  load_en, serial_in, sram_select, adc_bypass_en,
        output phase_wr_en, tf_coeff_wr_en, wr_addr, wr_data,
        output adc_bypass_data, load_busy, load_overflow, select_error
    );

endinterface

// File: rtl/serial_word_shifter.sv
// rtl/serial_word_shifter.sv - LSB-first bit collector with bit counter and word_done pulse
module serial_word_shifter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q;

    // word_o already includes the bit arriving this cycle, so the full word
    // is available at the same edge that captures the last bit.
    always_comb begin
        word_o            = shift_q;
        word_o[bit_cnt_q] = bit_i;
    end

    assign word_done_o = shift_en_i && (bit_cnt_q == LAST_BIT);

    always_comb begin
        bit_cnt_d = '0;
        if (shift_en_i && !word_done_o) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            if (shift_en_i) begin
                shift_q <= word_o;
            end
        end
    end

endmodule

// File: rtl/deconv_serial_loader.sv
// rtl/deconv_serial_loader.sv - serial word loader steering words to SRAMs or ADC bypass (option DECONV_LOADER_INPUT_SYNC_EN)
module deconv_serial_loader
    import deconv_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    deconv_serial_loader_if.slave  bus
);

    logic       load_en;
    logic       serial_in;
    logic [1:0] sram_select;
    logic       adc_bypass_en;

`ifdef DECONV_LOADER_INPUT_SYNC_EN
    logic [4:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.load_en, bus.serial_in, bus.sram_select, bus.adc_bypass_en};
            sync2_q <= sync1_q;
        end
    end

    assign {load_en, serial_in, sram_select, adc_bypass_en} = sync2_q;
`else
    assign load_en       = bus.load_en;
    assign serial_in     = bus.serial_in;
    assign sram_select   = bus.sram_select;
    assign adc_bypass_en = bus.adc_bypass_en;
`endif

    state_t                state_q, state_d;
    logic [1:0]            sel_q, sel_d, sel_eff;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                  phase_wr_q, phase_wr_d;
    logic                  tf_wr_q, tf_wr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] bypass_q, bypass_d;
    logic                  overflow_q, overflow_d;
    logic                  sel_err_q, sel_err_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;

    // Leaving SHIFT clears the bit counter, which drops any partial word.
    serial_word_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en_i  (load_en),
        .bit_i       (serial_in),
        .word_o      (word),
        .word_done_o (word_done)
    );

    // The select is latched on the first bit; use the live pins at that edge.
    assign sel_eff = (state_q == ST_IDLE) ? sram_select : sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d = ST_SHIFT;
                    sel_d   = sram_select;
                end
            end
            default: begin
                if (!load_en) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        phase_wr_d = 1'b0;
        tf_wr_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        bypass_d   = bypass_q;
        overflow_d = overflow_q;
        sel_err_d  = sel_err_q;
        word_cnt_d = load_en ? word_cnt_q : '0;
        if (word_done) begin
            if (adc_bypass_en) begin
                bypass_d = word;
            end else if (sel_eff == SEL_PHASE || sel_eff == SEL_TF_COEFF) begin
                phase_wr_d = (sel_eff == SEL_PHASE);
                tf_wr_d    = (sel_eff == SEL_TF_COEFF);
                wr_addr_d  = word_cnt_q;
                wr_data_d  = word;
                word_cnt_d = word_cnt_q + 1'b1;
                if (&word_cnt_q) begin
                    overflow_d = 1'b1;
                end
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_PHASE;
            word_cnt_q <= '0;
            phase_wr_q <= 1'b0;
            tf_wr_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            bypass_q   <= '0;
            overflow_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            word_cnt_q <= word_cnt_d;
            phase_wr_q <= phase_wr_d;
            tf_wr_q    <= tf_wr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            bypass_q   <= bypass_d;
            overflow_q <= overflow_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.phase_wr_en     = phase_wr_q;
    assign bus.tf_coeff_wr_en  = tf_wr_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.adc_bypass_data = bypass_q;
    assign bus.load_busy       = (state_q == ST_SHIFT);
    assign bus.load_overflow   = overflow_q;
    assign bus.select_error    = sel_err_q;

endmodule

// File: tb/tb_deconv_serial_loader.sv
// tb/tb_deconv_serial_loader.sv - scoreboard bench for deconv_serial_loader
module tb_deconv_serial_loader;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t          sb[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_bypass = '0;
    logic [DW-1:0] exp_wr_data = '0;
    logic [AW-1:0] exp_wr_addr = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_err = 1'b0;

    deconv_serial_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    deconv_serial_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.phase_wr_en || bus.tf_coeff_wr_en)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", {30'd0, bus.phase_wr_en, bus.tf_coeff_wr_en},
                      (e.sel == 2'b00) ? 32'd2 : 32'd1);
                check("strobe_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("strobe_data", 32'(bus.wr_data), 32'(e.data));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // Streams nwords full words plus extra bits, then holds load_en low for gap cycles.
    task automatic burst(input logic [1:0] sel, input logic byp, input int nwords,
                         input int extra, input int gap);
        int            addr = 0;
        int            nb   = nwords * DW + extra;
        logic [DW-1:0] w    = '0;
        for (int i = 0; i < nb; i++) begin
            if (i % DW == 0) w = (wq.size() > 0) ? wq.pop_front() : DW'($urandom);
            @(negedge clk);
            if (i == 1) check("busy_high", 32'(bus.load_busy), 32'd1);
            bus.load_en       = 1'b1;
            bus.serial_in     = w[i % DW];
            bus.sram_select   = (i == 0) ? sel : 2'($urandom);
            bus.adc_bypass_en = byp;
            if (i % DW == DW - 1) begin
                if (byp) begin
                    exp_bypass = w;
                end else if (sel < 2'd2) begin
                    sb.push_back('{sel, AW'(addr), w, cyc + 1});
                    exp_wr_addr = AW'(addr);
                    exp_wr_data = w;
                    if (addr == (1 << AW) - 1) exp_ovf = 1'b1;
                    addr = (addr + 1) % (1 << AW);
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        @(negedge clk);
        bus.load_en   = 1'b0;
        bus.serial_in = 1'($urandom);
        @(negedge clk);
        check("busy_low", 32'(bus.load_busy), 32'd0);
        bus.adc_bypass_en = 1'b0;
        for (int g = 2; g < gap; g++) @(negedge clk);
        check("bypass_data", 32'(bus.adc_bypass_data), 32'(exp_bypass));
        check("overflow", 32'(bus.load_overflow), 32'(exp_ovf));
        check("select_error", 32'(bus.select_error), 32'(exp_err));
        check("wr_addr_hold", 32'(bus.wr_addr), 32'(exp_wr_addr));
        check("wr_data_hold", 32'(bus.wr_data), 32'(exp_wr_data));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"}, 32'(bus.phase_wr_en), 32'd0);
        check({tag, "_tf"}, 32'(bus.tf_coeff_wr_en), 32'd0);
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_bypass"}, 32'(bus.adc_bypass_data), 32'd0);
        check({tag, "_busy"}, 32'(bus.load_busy), 32'd0);
        check({tag, "_ovf"}, 32'(bus.load_overflow), 32'd0);
        check({tag, "_err"}, 32'(bus.select_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w = '0;
        bus.load_en = 1'b0;
        bus.serial_in = 1'b0;
        bus.sram_select = 2'b00;
        bus.adc_bypass_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        wq.push_back(16'hA5C3);
        wq.push_back(16'h1234);
        burst(2'b00, 1'b0, 2, 0, 3);

        burst(2'b01, 1'b0, 3, 0, 2);
        burst(2'b01, 1'b0, 2, 0, 3);

        wq.push_back(16'h004F);
        burst(2'b00, 1'b1, 1, 0, 3);
        check("bypass_004f", 32'(bus.adc_bypass_data), 32'h004F);

        burst(2'b00, 1'b0, 0, 7, 2);
        burst(2'b00, 1'b0, 1, 0, 2);

        for (int r = 0; r < 6; r++) begin
            burst(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  $urandom_range(1, 3), $urandom_range(0, DW - 1), $urandom_range(2, 4));
        end

        burst(2'b00, 1'b0, 9, 0, 3);
        check("overflow_after_wrap", 32'(bus.load_overflow), 32'd1);
        burst(2'b10, 1'b0, 1, 0, 3);
        check("select_error_set", 32'(bus.select_error), 32'd1);

        for (int i = 0; i < DW + 5; i++) begin
            if (i % DW == 0) w = DW'($urandom);
            @(negedge clk);
            bus.load_en = 1'b1;
            bus.serial_in = w[i % DW];
            bus.sram_select = 2'b01;
            if (i == DW - 1) sb.push_back('{2'b01, AW'(0), w, cyc + 1});
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.load_en = 1'b0;
        #1 check_all_zero("midreset");
        exp_bypass = '0;
        exp_wr_data = '0;
        exp_wr_addr = '0;
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        burst(2'b01, 1'b0, 2, 0, 3);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
